// File: rtl/mdio_transmitter.sv
// MDIO management-station transmitter: serialises Clause-22 frames on MDC,
// with optional preamble, and captures 16 bits of read data after turnaround.
module mdio_transmitter #(
  parameter int PRE_BITS = 32
) (
  input  logic        MDC,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic        MDIO_DONE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY,
  output logic        ERR
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRE   = 3'd1;
  localparam logic [2:0] HDR   = 3'd2;
  localparam logic [2:0] WDATA = 3'd3;
  localparam logic [2:0] TA_R  = 3'd4;
  localparam logic [2:0] RDATA = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  localparam logic [5:0] PRE_LAST = 6'(PRE_BITS - 1);

  // state names the phase that the next edge will put on the line
  logic [2:0]  state;
  logic [31:0] tx_sr;
  logic [15:0] rx_sr;
  logic [5:0]  bit_cnt;
  logic [5:0]  pre_cnt;
  logic        is_read;
  logic        req_ok;

  assign req_ok = (T_DATA[31:30] == 2'b01) &&
                  ((T_DATA[29:28] == 2'b01) || (T_DATA[29:28] == 2'b10));

  always_ff @(posedge MDC) begin
    if (RESET) begin
      state     <= IDLE;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      pre_cnt   <= '0;
      is_read   <= 1'b0;
      MDIO_OUT  <= 1'b0;
      MDIO_OE   <= 1'b0;
      MDIO_DONE <= 1'b0;
      RD_DATA   <= '0;
      DATA_RDY  <= 1'b0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      MDIO_DONE <= 1'b0;
      DATA_RDY  <= 1'b0;
      ERR       <= 1'b0;
      case (state)
        IDLE: begin
          MDIO_OE  <= 1'b0;
          MDIO_OUT <= 1'b0;
          BUSY     <= 1'b0;
          if (MDIO_START) begin
            if (req_ok) begin
              tx_sr   <= T_DATA;
              is_read <= (T_DATA[29:28] == 2'b10);
              BUSY    <= 1'b1;
              pre_cnt <= '0;
              bit_cnt <= '0;
              state   <= (PRE_BITS == 0) ? HDR : PRE;
            end else begin
              ERR <= 1'b1;
            end
          end
        end
        PRE: begin
          MDIO_OE  <= 1'b1;
          MDIO_OUT <= 1'b1;
          pre_cnt  <= pre_cnt + 6'd1;
          if (pre_cnt == PRE_LAST) state <= HDR;
        end
        HDR: begin
          MDIO_OE  <= 1'b1;
          MDIO_OUT <= tx_sr[31];
          tx_sr    <= {tx_sr[30:0], 1'b0};
          bit_cnt  <= bit_cnt + 6'd1;
          if (bit_cnt == 6'd13) state <= is_read ? TA_R : WDATA;
        end
        WDATA: begin
          // turnaround is always 2'b10 on writes, whatever the request held
          MDIO_OE  <= 1'b1;
          MDIO_OUT <= (bit_cnt == 6'd14) ? 1'b1 :
                      (bit_cnt == 6'd15) ? 1'b0 : tx_sr[31];
          tx_sr    <= {tx_sr[30:0], 1'b0};
          bit_cnt  <= bit_cnt + 6'd1;
          if (bit_cnt == 6'd31) state <= DONE;
        end
        TA_R: begin
          MDIO_OE  <= 1'b0;
          MDIO_OUT <= 1'b0;
          bit_cnt  <= bit_cnt + 6'd1;
          if (bit_cnt == 6'd15) state <= RDATA;
        end
        RDATA: begin
          MDIO_OE  <= 1'b0;
          MDIO_OUT <= 1'b0;
          rx_sr    <= {rx_sr[14:0], MDIO_IN};
          bit_cnt  <= bit_cnt + 6'd1;
          if (bit_cnt == 6'd31) state <= DONE;
        end
        DONE: begin
          MDIO_OE   <= 1'b0;
          MDIO_OUT  <= 1'b0;
          MDIO_DONE <= 1'b1;
          if (is_read) begin
            RD_DATA  <= rx_sr;
            DATA_RDY <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_transmitter.sv
// Directed bench for mdio_transmitter: a vector table for request validation
// plus cycle-by-cycle frame checks against a bit-level model (P=32 and P=0).
module tb_mdio_transmitter;

  logic MDC = 1'b0;
  always #5 MDC = ~MDC;

  logic        rst, start, mdio_in, sel;
  logic [31:0] td;

  logic        out32, oe32, done32, rdy32, busy32, err32;
  logic [15:0] rd32;
  logic        out0, oe0, done0, rdy0, busy0, err0;
  logic [15:0] rd0;

  mdio_transmitter #(.PRE_BITS(32)) dut32 (
    .MDC(MDC), .RESET(rst), .MDIO_START(start & ~sel), .T_DATA(td),
    .MDIO_IN(mdio_in), .MDIO_OUT(out32), .MDIO_OE(oe32), .MDIO_DONE(done32),
    .RD_DATA(rd32), .DATA_RDY(rdy32), .BUSY(busy32), .ERR(err32)
  );

  mdio_transmitter #(.PRE_BITS(0)) dut0 (
    .MDC(MDC), .RESET(rst), .MDIO_START(start & sel), .T_DATA(td),
    .MDIO_IN(mdio_in), .MDIO_OUT(out0), .MDIO_OE(oe0), .MDIO_DONE(done0),
    .RD_DATA(rd0), .DATA_RDY(rdy0), .BUSY(busy0), .ERR(err0)
  );

  // {busy, oe, out, done, rdy, err, rd_data}
  logic [21:0] obs;
  assign obs = sel ? {busy0, oe0, out0, done0, rdy0, err0, rd0}
                   : {busy32, oe32, out32, done32, rdy32, err32, rd32};

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_rd [2];

  typedef struct {
    logic        rst;
    logic        start;
    logic [31:0] td;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  task automatic check(input string name, input int k, input logic [21:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s k=%0d: got busy,oe,out,done,rdy,err=%b rd=%h, expected %b rd=%h",
               name, k, obs[21:16], obs[15:0], exp[21:16], exp[15:0]);
    end
  endtask

  task automatic step();
    @(posedge MDC);
    @(negedge MDC);
  endtask

  task automatic issue_start(input logic s, input logic [31:0] t);
    sel   = s;
    start = 1'b1;
    td    = t;
    step();
    start = 1'b0;
  endtask

  // Entered at the negedge after E0 of the frame described by t.
  task automatic run_frame(input string name, input int p, input logic [31:0] t,
                           input logic [15:0] rdv, input int inj_k, input int rst_k,
                           input bit chain, input logic [31:0] next_t);
    bit rd;
    int nk, j;
    logic b, oe, o, dn, dr;
    rd = (t[29:28] == 2'b10);
    for (int k = 0; k <= p + 34; k++) begin
      b  = (k <= p + 33) || chain;
      oe = 1'b0;
      o  = 1'b0;
      j  = k - p - 1;
      if (k >= 1 && k <= p) begin
        oe = 1'b1; o = 1'b1;
      end else if (k >= p + 1 && k <= p + 14) begin
        oe = 1'b1; o = t[31 - j];
      end else if (!rd && k >= p + 15 && k <= p + 32) begin
        oe = 1'b1;
        o  = (j == 14) ? 1'b1 : (j == 15) ? 1'b0 : t[31 - j];
      end
      dn = (k == p + 33);
      dr = dn && rd;
      if (dr) exp_rd[sel] = rdv;
      check(name, k, {b, oe, o, dn, dr, 1'b0, exp_rd[sel]});
      if (k == p + 34) break;

      nk = k + 1;
      if (nk >= p + 17 && nk <= p + 32) mdio_in = rdv[p + 32 - nk];
      else mdio_in = (nk < p + 17);
      if (nk == inj_k) begin start = 1'b1; td = 32'h6FFF0000; end
      if (nk == rst_k) rst = 1'b1;
      if (chain && nk == p + 34) begin start = 1'b1; td = next_t; end
      step();
      start = 1'b0;
      if (nk == rst_k) begin
        rst = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        check({name, "_after_reset"}, nk, 22'h0);
        return;
      end
    end
  endtask

  vec_t vecs [10];

  initial begin
    rst = 1'b1; start = 1'b0; td = '0; mdio_in = 1'b0; sel = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    vecs[0] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h51AABEEF, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h41AA0000, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h41AA0000, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h91AA0000, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 32'hC1AA0000, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 32'h31AA0000, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 32'h71AA0000, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0};

    @(negedge MDC);
    for (int i = 0; i < 10; i++) begin
      rst   = vecs[i].rst;
      start = vecs[i].start;
      td    = vecs[i].td;
      step();
      check("vec", i, {vecs[i].e_busy, 5'b0, vecs[i].e_err, 16'h0000} >> 0);
    end
    start = 1'b0;
    rst   = 1'b0;

    issue_start(1'b0, 32'h51AABEEF);
    run_frame("wr32", 32, 32'h51AABEEF, 16'h0, -1, -1, 1'b0, 32'h0);

    issue_start(1'b0, 32'h61A80000);
    run_frame("rd32", 32, 32'h61A80000, 16'hC3A5, -1, -1, 1'b0, 32'h0);

    issue_start(1'b0, 32'h51A8BEEF);
    run_frame("busy32", 32, 32'h51A8BEEF, 16'h0, 10, -1, 1'b0, 32'h0);

    issue_start(1'b0, 32'h51AABEEF);
    run_frame("rst32", 32, 32'h51AABEEF, 16'h0, -1, 20, 1'b0, 32'h0);

    issue_start(1'b0, 32'h51AABEEF);
    run_frame("wr32_post_rst", 32, 32'h51AABEEF, 16'h0, -1, -1, 1'b0, 32'h0);

    issue_start(1'b1, 32'h5A5A0F0F);
    run_frame("wr0", 0, 32'h5A5A0F0F, 16'h0, -1, -1, 1'b1, 32'h6D040000);
    run_frame("rd0", 0, 32'h6D040000, 16'h1E69, -1, -1, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
